// File: rtl/axi4_outstanding_limiter.sv
// AXI4 outstanding-burst limiter: caps in-flight write/read bursts and holds W beats until their AW is accepted.
// Optional watchdog is enabled by defining AXI4_LIMITER_TIMEOUT_EN.
module axi4_outstanding_limiter
  #(parameter int id_width_p       = 4
   ,parameter int addr_width_p     = 32
   ,parameter int data_width_p     = 64
   ,parameter int max_wr_p         = 8
   ,parameter int max_rd_p         = 8
   ,parameter int timeout_cycles_p = 4096
   ,localparam int mosi_width_lp   = 2*(id_width_p+addr_width_p+25)+data_width_p+data_width_p/8+4
   ,localparam int miso_width_lp   = 2*id_width_p+data_width_p+10
   ,localparam int wr_w_lp         = $clog2(max_wr_p+1)
   ,localparam int rd_w_lp         = $clog2(max_rd_p+1))
  (input  logic                     clk_i
  ,input  logic                     reset_i
  ,input  logic [mosi_width_lp-1:0] s_axi4_i
  ,output logic [miso_width_lp-1:0] s_axi4_o
  ,output logic [mosi_width_lp-1:0] m_axi4_o
  ,input  logic [miso_width_lp-1:0] m_axi4_i
  ,output logic [wr_w_lp-1:0]       wr_outstanding_o
  ,output logic [rd_w_lp-1:0]       rd_outstanding_o
  ,output logic                     idle_o
  ,output logic                     protocol_err_o
  ,output logic                     timeout_o
  );

   // Packed bus layout, MSB first.
   typedef struct packed {
      logic [id_width_p-1:0]     awid;
      logic [addr_width_p-1:0]   awaddr;
      logic [7:0]                awlen;
      logic [2:0]                awsize;
      logic [1:0]                awburst;
      logic [3:0]                awcache;
      logic [2:0]                awprot;
      logic [3:0]                awqos;
      logic                      awvalid;
      logic [data_width_p-1:0]   wdata;
      logic [data_width_p/8-1:0] wstrb;
      logic                      wlast;
      logic                      wvalid;
      logic                      bready;
      logic [id_width_p-1:0]     arid;
      logic [addr_width_p-1:0]   araddr;
      logic [7:0]                arlen;
      logic [2:0]                arsize;
      logic [1:0]                arburst;
      logic [3:0]                arcache;
      logic [2:0]                arprot;
      logic [3:0]                arqos;
      logic                      arvalid;
      logic                      rready;
   } mosi_s;

   typedef struct packed {
      logic                      awready;
      logic                      wready;
      logic [id_width_p-1:0]     bid;
      logic [1:0]                bresp;
      logic                      bvalid;
      logic                      arready;
      logic [id_width_p-1:0]     rid;
      logic [data_width_p-1:0]   rdata;
      logic [1:0]                rresp;
      logic                      rlast;
      logic                      rvalid;
   } miso_s;

   localparam logic [wr_w_lp-1:0] max_wr_lp = wr_w_lp'(max_wr_p);
   localparam logic [rd_w_lp-1:0] max_rd_lp = rd_w_lp'(max_rd_p);

   mosi_s s_req, m_req;
   miso_s s_rsp, m_rsp;

   logic [wr_w_lp-1:0] wr_cnt, w_cred;
   logic [rd_w_lp-1:0] rd_cnt;
   logic               perr_r;
   logic               aw_ok, ar_ok, w_ok;
   logic               aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;

   assign s_req = s_axi4_i;
   assign m_rsp = m_axi4_i;

   assign aw_ok = (wr_cnt < max_wr_lp) & ~reset_i;
   assign ar_ok = (rd_cnt < max_rd_lp) & ~reset_i;
   assign w_ok  = (w_cred != '0) & ~reset_i;

   always_comb begin
      m_req         = s_req;
      s_rsp         = m_rsp;
      m_req.awvalid = s_req.awvalid & aw_ok;
      s_rsp.awready = m_rsp.awready & aw_ok;
      m_req.wvalid  = s_req.wvalid  & w_ok;
      s_rsp.wready  = m_rsp.wready  & w_ok;
      m_req.arvalid = s_req.arvalid & ar_ok;
      s_rsp.arready = m_rsp.arready & ar_ok;
   end

   assign m_axi4_o = m_req;
   assign s_axi4_o = s_rsp;

   // All handshakes are taken on the downstream side of the gate.
   assign aw_hs     = m_req.awvalid & m_rsp.awready;
   assign ar_hs     = m_req.arvalid & m_rsp.arready;
   assign w_last_hs = m_req.wvalid  & m_rsp.wready & m_req.wlast;
   assign b_hs      = m_rsp.bvalid  & m_req.bready;
   assign r_last_hs = m_rsp.rvalid  & m_req.rready & m_rsp.rlast;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
         w_cred <= '0;
         perr_r <= 1'b0;
      end else begin
         if (aw_hs & ~b_hs)
            wr_cnt <= wr_cnt + wr_w_lp'(1);
         else if (b_hs & ~aw_hs & (wr_cnt != '0))
            wr_cnt <= wr_cnt - wr_w_lp'(1);

         if (ar_hs & ~r_last_hs)
            rd_cnt <= rd_cnt + rd_w_lp'(1);
         else if (r_last_hs & ~ar_hs & (rd_cnt != '0))
            rd_cnt <= rd_cnt - rd_w_lp'(1);

         // Credit is registered, so an AW accepted this cycle only releases W next cycle.
         if (aw_hs & ~w_last_hs)
            w_cred <= w_cred + wr_w_lp'(1);
         else if (w_last_hs & ~aw_hs)
            w_cred <= w_cred - wr_w_lp'(1);

         if ((b_hs & (wr_cnt == '0)) | (r_last_hs & (rd_cnt == '0)))
            perr_r <= 1'b1;
      end
   end

   assign wr_outstanding_o = wr_cnt;
   assign rd_outstanding_o = rd_cnt;
   assign idle_o           = (wr_cnt == '0) & (rd_cnt == '0) & (w_cred == '0);
   assign protocol_err_o   = perr_r;

`ifdef AXI4_LIMITER_TIMEOUT_EN
   localparam int to_w_lp = $clog2(timeout_cycles_p+1);
   localparam logic [to_w_lp-1:0] to_max_lp = to_w_lp'(timeout_cycles_p);

   logic [to_w_lp-1:0] wr_wd, rd_wd;
   logic               timeout_r;

   // Watchdogs only observe; traffic keeps flowing after a timeout.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_wd     <= '0;
         rd_wd     <= '0;
         timeout_r <= 1'b0;
      end else begin
         if (b_hs | (wr_cnt == '0))
            wr_wd <= '0;
         else if (wr_wd != to_max_lp)
            wr_wd <= wr_wd + to_w_lp'(1);

         if (r_last_hs | (rd_cnt == '0))
            rd_wd <= '0;
         else if (rd_wd != to_max_lp)
            rd_wd <= rd_wd + to_w_lp'(1);

         if ((wr_wd == to_max_lp) | (rd_wd == to_max_lp))
            timeout_r <= 1'b1;
      end
   end

   assign timeout_o = timeout_r;
`else
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_outstanding_limiter.sv
// Bench for axi4_outstanding_limiter: vector table, directed corner sequences and a random run
// checked against a count-based reference model.
module tb_axi4_outstanding_limiter;

   localparam int idw = 2;
   localparam int adw = 8;
   localparam int dw  = 8;
   localparam int mw  = 2;
   localparam int mr  = 4;
   localparam int tmo_cyc = 16;

   typedef struct packed {
      logic [idw-1:0]  awid;
      logic [adw-1:0]  awaddr;
      logic [7:0]      awlen;
      logic [2:0]      awsize;
      logic [1:0]      awburst;
      logic [3:0]      awcache;
      logic [2:0]      awprot;
      logic [3:0]      awqos;
      logic            awvalid;
      logic [dw-1:0]   wdata;
      logic [dw/8-1:0] wstrb;
      logic            wlast;
      logic            wvalid;
      logic            bready;
      logic [idw-1:0]  arid;
      logic [adw-1:0]  araddr;
      logic [7:0]      arlen;
      logic [2:0]      arsize;
      logic [1:0]      arburst;
      logic [3:0]      arcache;
      logic [2:0]      arprot;
      logic [3:0]      arqos;
      logic            arvalid;
      logic            rready;
   } mosi_t;

   typedef struct packed {
      logic            awready;
      logic            wready;
      logic [idw-1:0]  bid;
      logic [1:0]      bresp;
      logic            bvalid;
      logic            arready;
      logic [idw-1:0]  rid;
      logic [dw-1:0]   rdata;
      logic [1:0]      rresp;
      logic            rlast;
      logic            rvalid;
   } miso_t;

   // in = {awv,awr,wv,wl,wr,bv,br,arv,arr,rv,rl,rr}; gate = {m.awvalid,s.awready,m.wvalid,s.wready,m.arvalid,s.arready}
   typedef struct {
      logic [11:0] in;
      logic [5:0]  gate;
      int          wcnt;
      int          rcnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   mosi_t       s_req, m_req;
   miso_t       s_rsp, m_rsp;
   logic [1:0]  wr_o;
   logic [2:0]  rd_o;
   logic        idle, perr, tmo;

   int n_cmp = 0;
   int n_bad = 0;
   int m_wr, m_rd, m_cred, m_err;

   axi4_outstanding_limiter #(
      .id_width_p(idw), .addr_width_p(adw), .data_width_p(dw),
      .max_wr_p(mw), .max_rd_p(mr), .timeout_cycles_p(tmo_cyc)
   ) dut (
      .clk_i(clk), .reset_i(rst),
      .s_axi4_i(s_req), .s_axi4_o(s_rsp),
      .m_axi4_o(m_req), .m_axi4_i(m_rsp),
      .wr_outstanding_o(wr_o), .rd_outstanding_o(rd_o),
      .idle_o(idle), .protocol_err_o(perr), .timeout_o(tmo)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      s_req = '0;
      m_rsp = '0;
   endtask

   task automatic do_reset();
      clear_in();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      m_wr = 0; m_rd = 0; m_cred = 0; m_err = 0;
   endtask

   function automatic logic [5:0] gates();
      return {m_req.awvalid, s_rsp.awready, m_req.wvalid, s_rsp.wready, m_req.arvalid, s_rsp.arready};
   endfunction

   task automatic apply_vec(input logic [11:0] v);
      {s_req.awvalid, m_rsp.awready, s_req.wvalid, s_req.wlast, m_rsp.wready, m_rsp.bvalid,
       s_req.bready, s_req.arvalid, m_rsp.arready, m_rsp.rvalid, m_rsp.rlast, s_req.rready} = v;
   endtask

   // Reference model: outputs and next counts from the channel rules, with the counts as plain integers.
   task automatic model_check_and_step();
      mosi_t e_req;
      miso_t e_rsp;
      int aw, ar, wl, b, r;
      e_req = s_req;
      e_req.awvalid = s_req.awvalid && (m_wr < mw);
      e_req.wvalid  = s_req.wvalid  && (m_cred != 0);
      e_req.arvalid = s_req.arvalid && (m_rd < mr);
      e_rsp = m_rsp;
      e_rsp.awready = m_rsp.awready && (m_wr < mw);
      e_rsp.wready  = m_rsp.wready  && (m_cred != 0);
      e_rsp.arready = m_rsp.arready && (m_rd < mr);
      chk("rnd_m_req", 128'(m_req), 128'(e_req));
      chk("rnd_s_rsp", 128'(s_rsp), 128'(e_rsp));
      chk("rnd_wr_cnt", 128'(wr_o), 128'(m_wr));
      chk("rnd_rd_cnt", 128'(rd_o), 128'(m_rd));
      chk("rnd_idle", 128'(idle), 128'(m_wr == 0 && m_rd == 0 && m_cred == 0));
      chk("rnd_perr", 128'(perr), 128'(m_err));
`ifndef AXI4_LIMITER_TIMEOUT_EN
      chk("rnd_timeout", 128'(tmo), 128'(0));
`endif
      aw = (e_req.awvalid && m_rsp.awready) ? 1 : 0;
      ar = (e_req.arvalid && m_rsp.arready) ? 1 : 0;
      wl = (e_req.wvalid && m_rsp.wready && s_req.wlast) ? 1 : 0;
      b  = (m_rsp.bvalid && s_req.bready) ? 1 : 0;
      r  = (m_rsp.rvalid && s_req.rready && m_rsp.rlast) ? 1 : 0;
      if ((b == 1 && m_wr == 0) || (r == 1 && m_rd == 0)) m_err = 1;
      m_wr   = (m_wr + aw - b < 0) ? 0 : m_wr + aw - b;
      m_rd   = (m_rd + ar - r < 0) ? 0 : m_rd + ar - r;
      m_cred = m_cred + aw - wl;
   endtask

   vec_t tbl[14];

   initial begin
      int beats;
      logic [95:0] rnd;
      logic [31:0] rnd32;
      bit seen;

      tbl[0]  = '{12'b1111_1000_0000, 6'b110000, 1, 0};
      tbl[1]  = '{12'b1111_1000_0000, 6'b111100, 2, 0};
      tbl[2]  = '{12'b1110_1000_0000, 6'b001100, 2, 0};
      tbl[3]  = '{12'b0011_1110_0000, 6'b001100, 1, 0};
      tbl[4]  = '{12'b1011_1000_0000, 6'b100000, 1, 0};
      tbl[5]  = '{12'b0000_0001_1000, 6'b000011, 1, 1};
      tbl[6]  = '{12'b0000_0001_1111, 6'b000011, 1, 1};
      tbl[7]  = '{12'b0000_0000_0101, 6'b000000, 1, 1};
      tbl[8]  = '{12'b0000_0110_0111, 6'b000000, 0, 0};
      tbl[9]  = '{12'b0000_0001_1000, 6'b000011, 0, 1};
      tbl[10] = '{12'b0000_0001_1000, 6'b000011, 0, 2};
      tbl[11] = '{12'b0000_0001_1000, 6'b000011, 0, 3};
      tbl[12] = '{12'b0000_0001_1000, 6'b000011, 0, 4};
      tbl[13] = '{12'b0000_0001_1000, 6'b000000, 0, 4};

      // Reset state, with requests driven so the forced gating is visible.
      clear_in();
      s_req.awvalid = 1'b1; m_rsp.awready = 1'b1;
      s_req.arvalid = 1'b1; m_rsp.arready = 1'b1;
      tick();
      chk("rst_gates", 128'(gates()), 128'(0));
      chk("rst_wr_cnt", 128'(wr_o), 128'(0));
      chk("rst_rd_cnt", 128'(rd_o), 128'(0));
      chk("rst_idle", 128'(idle), 128'(1));
      chk("rst_perr", 128'(perr), 128'(0));
      chk("rst_timeout", 128'(tmo), 128'(0));
      do_reset();

      for (int i = 0; i < 14; i++) begin
         apply_vec(tbl[i].in);
         #1;
         chk($sformatf("vec%0d_gates", i), 128'(gates()), 128'(tbl[i].gate));
         tick();
         chk($sformatf("vec%0d_wr_cnt", i), 128'(wr_o), 128'(tbl[i].wcnt));
         chk($sformatf("vec%0d_rd_cnt", i), 128'(rd_o), 128'(tbl[i].rcnt));
      end
      do_reset();

      // Write limit with the slave holding B.
      s_req.awvalid = 1'b1; m_rsp.awready = 1'b1; s_req.bready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1 chk($sformatf("lim_aw%0d_ready", i), 128'(s_rsp.awready), 128'(1));
         tick();
      end
      chk("lim_wr_cnt_full", 128'(wr_o), 128'(2));
      chk("lim_aw3_blocked", 128'({m_req.awvalid, s_rsp.awready}), 128'(0));
      tick();
      chk("lim_aw3_still_blocked", 128'(s_rsp.awready), 128'(0));
      m_rsp.bvalid = 1'b1;
      #1 chk("lim_aw3_blocked_at_b", 128'(s_rsp.awready), 128'(0));
      tick();
      m_rsp.bvalid = 1'b0;
      #1 chk("lim_aw3_ready_after_b", 128'(s_rsp.awready), 128'(1));
      tick();
      chk("lim_wr_cnt_refill", 128'(wr_o), 128'(2));
      do_reset();

      // W beats presented before their AW.
      s_req.wvalid = 1'b1; m_rsp.wready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("word_early%0d", i), 128'({m_req.wvalid, s_rsp.wready}), 128'(0));
         tick();
      end
      s_req.awvalid = 1'b1; m_rsp.awready = 1'b1; s_req.awlen = 8'd3;
      #1 chk("word_same_cycle", 128'(m_req.wvalid), 128'(0));
      tick();
      s_req.awvalid = 1'b0;
      beats = 0;
      for (int i = 0; i < 10 && s_req.wvalid; i++) begin
         s_req.wlast = (beats == 3);
         #1;
         if (m_req.wvalid && m_rsp.wready) beats++;
         tick();
         if (s_req.wlast && beats == 4) s_req.wvalid = 1'b0;
      end
      chk("word_beats", 128'(beats), 128'(4));
      s_req.wvalid = 1'b1; s_req.wlast = 1'b0;
      #1 chk("word_cred_empty", 128'(m_req.wvalid), 128'(0));
      s_req.wvalid = 1'b0;

      // Simultaneous increment/decrement, write count is 1 here.
      s_req.awvalid = 1'b1; m_rsp.bvalid = 1'b1; s_req.bready = 1'b1;
      #1 chk("sim_aw_accept", 128'(s_rsp.awready), 128'(1));
      tick();
      clear_in();
      chk("sim_wr_cnt", 128'(wr_o), 128'(1));
      s_req.arvalid = 1'b1; m_rsp.arready = 1'b1;
      tick();
      m_rsp.rvalid = 1'b1; m_rsp.rlast = 1'b1; s_req.rready = 1'b1;
      tick();
      clear_in();
      chk("sim_rd_cnt", 128'(rd_o), 128'(1));
      do_reset();

      // Random traffic against the reference model; B and R only when a matching burst exists.
      for (int c = 0; c < 3000; c++) begin
         rnd = {$urandom, $urandom, $urandom};
         s_req = rnd[$bits(mosi_t)-1:0];
         rnd32 = $urandom;
         m_rsp = rnd32[$bits(miso_t)-1:0];
         m_rsp.bvalid = (m_wr > m_cred) && ($urandom_range(0, 1) == 1);
         m_rsp.rvalid = (m_rd > 0) && ($urandom_range(0, 1) == 1);
         #1;
         model_check_and_step();
         tick();
      end
      do_reset();

      // Stray B with nothing outstanding.
      m_rsp.bvalid = 1'b1; s_req.bready = 1'b1;
      #1 chk("err_before_edge", 128'(perr), 128'(0));
      tick();
      clear_in();
      chk("err_set", 128'(perr), 128'(1));
      chk("err_wr_cnt", 128'(wr_o), 128'(0));
      repeat (3) tick();
      chk("err_sticky", 128'(perr), 128'(1));

      // Asynchronous reset in the middle of a read burst.
      s_req.arvalid = 1'b1; m_rsp.arready = 1'b1;
      repeat (3) tick();
      s_req.arvalid = 1'b0;
      m_rsp.rvalid = 1'b1; s_req.rready = 1'b1;
      repeat (2) tick();
      chk("mid_rd_cnt", 128'(rd_o), 128'(3));
      s_req.awvalid = 1'b1; m_rsp.awready = 1'b1; s_req.wvalid = 1'b1; m_rsp.wready = 1'b1;
      s_req.arvalid = 1'b1; s_req.bready = 1'b1;
      #1 chk("mid_aw_open", 128'(m_req.awvalid), 128'(1));
      rst = 1'b1;
      #1;
      chk("arst_gates", 128'(gates()), 128'(0));
      chk("arst_counts", 128'({wr_o, rd_o}), 128'(0));
      chk("arst_idle", 128'(idle), 128'(1));
      chk("arst_perr", 128'(perr), 128'(0));
      chk("arst_ready_pass", 128'({m_req.bready, m_req.rready}), 128'(2'b11));
      tick();
      rst = 1'b0;
      clear_in();

`ifdef AXI4_LIMITER_TIMEOUT_EN
      do_reset();
      s_req.arvalid = 1'b1; m_rsp.arready = 1'b1;
      tick();
      clear_in();
      repeat (10) tick();
      chk("tmo_early", 128'(tmo), 128'(0));
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         seen = tmo;
      end
      chk("tmo_stall", 128'(seen), 128'(1));
      do_reset();
      s_req.arvalid = 1'b1; m_rsp.arready = 1'b1;
      tick();
      clear_in();
      repeat (9) tick();
      m_rsp.rvalid = 1'b1; m_rsp.rlast = 1'b1; s_req.rready = 1'b1;
      tick();
      clear_in();
      repeat (30) tick();
      chk("tmo_none", 128'(tmo), 128'(0));
`else
      seen = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
